// File: rtl/calc_sequencer_if.sv
// Keypad-event inputs, arithmetic-block feedback and sequencer outputs for calc_sequencer.
// The master drives key events and the arithmetic answer; the slave (sequencer) drives operands and control.
interface calc_sequencer_if;
  logic        hex_valid;
  logic [3:0]  hex_digit;
  logic        op_valid;
  logic [1:0]  op_code;
  logic        eq_valid;
  logic        neg_valid;
  logic        clr_valid;
  logic [16:0] arth_answer;
  logic        arth_ovw;
  logic [16:0] V1;
  logic [16:0] V2;
  logic [1:0]  opcode;
  logic        newop;
  logic        newhex;
  logic        eq;
  logic [16:0] disp;
  logic        err;
  logic        busy;

  modport master (
    output hex_valid, hex_digit, op_valid, op_code, eq_valid, neg_valid, clr_valid,
    output arth_answer, arth_ovw,
    input  V1, V2, opcode, newop, newhex, eq, disp, err, busy
  );

  modport slave (
    input  hex_valid, hex_digit, op_valid, op_code, eq_valid, neg_valid, clr_valid,
    input  arth_answer, arth_ovw,
    output V1, V2, opcode, newop, newhex, eq, disp, err, busy
  );
endinterface

// File: rtl/calc_sequencer.sv
// Hex-calculator key sequencer: builds V1/V2 operands, pulses the arithmetic block, latches results.
// All outputs registered (1 cycle); events other than clr are dropped while the settle counter runs.
module calc_sequencer #(
  parameter int SETTLE = 3,
  parameter int MAXDIG = 4
) (
  input logic             clock,
  input logic             reset,
  calc_sequencer_if.slave bus
);
  typedef enum logic [2:0] {ENTRY1, OP_PENDING, ENTRY2, EVAL, RESULT, ERROR} state_t;

  localparam int CW = $clog2(SETTLE + 1);
  localparam int DW = $clog2(MAXDIG + 1);

  state_t        r_state, w_state;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [DW-1:0] r_dcnt, w_dcnt;
  logic [16:0]   r_v1, w_v1, r_v2, w_v2, r_res, w_res, r_disp, w_disp;
  logic [1:0]    r_opc, w_opc;
  logic          r_newop, w_newop, r_newhex, w_newhex, r_eq, w_eq, r_err, w_err, r_busy, w_busy;
  logic          w_idle, w_eqk, w_opk, w_hexk, w_negk, w_acc, w_op_ok, w_dig_ok;

  // Zero magnitude always carries a positive sign.
  function automatic logic [16:0] norm(input logic [16:0] v);
    return (v[15:0] == 16'd0) ? 17'd0 : v;
  endfunction

  always_comb begin
    w_idle   = (r_cnt == '0);
    w_eqk    = w_idle && !bus.clr_valid && bus.eq_valid;
    w_opk    = w_idle && !bus.clr_valid && !bus.eq_valid && bus.op_valid;
    w_hexk   = w_idle && !bus.clr_valid && !bus.eq_valid && !bus.op_valid && bus.hex_valid;
    w_negk   = w_idle && !bus.clr_valid && !bus.eq_valid && !bus.op_valid && !bus.hex_valid
               && bus.neg_valid;
    w_op_ok  = w_opk && (bus.op_code != 2'b11);
    w_dig_ok = w_hexk && (r_dcnt != DW'(MAXDIG));
    w_state  = r_state;
    w_v1     = r_v1;
    w_v2     = r_v2;
    w_res    = r_res;
    w_opc    = r_opc;
    w_dcnt   = r_dcnt;
    w_newop  = 1'b0;
    w_newhex = 1'b0;
    w_eq     = 1'b0;
    w_acc    = 1'b0;
    w_cnt    = w_idle ? '0 : r_cnt - CW'(1);

    case (r_state)
      ENTRY1, ENTRY2: begin
        if (w_eqk) begin
          w_eq  = 1'b1;
          w_acc = 1'b1;
          if (r_state == ENTRY1) begin
            w_res   = norm(r_v1);
            w_state = RESULT;
          end else begin
            w_state = EVAL;
          end
        end else if (w_op_ok) begin
          // Chaining folds the pending operation into V2 using the old operator.
          w_v2    = (r_state == ENTRY1) ? norm(r_v1) : norm(bus.arth_answer);
          w_v1    = '0;
          w_dcnt  = '0;
          w_opc   = bus.op_code;
          w_newop = 1'b1;
          w_acc   = 1'b1;
          w_state = OP_PENDING;
        end else if (w_dig_ok) begin
          w_v1     = norm({r_v1[16], r_v1[11:0], bus.hex_digit});
          w_dcnt   = r_dcnt + DW'(1);
          w_newhex = 1'b1;
          w_acc    = 1'b1;
        end else if (w_negk) begin
          w_v1     = norm({~r_v1[16], r_v1[15:0]});
          w_newhex = 1'b1;
          w_acc    = 1'b1;
        end
      end
      OP_PENDING: begin
        if (w_op_ok) begin
          w_opc   = bus.op_code;
          w_newop = 1'b1;
          w_acc   = 1'b1;
        end else if (w_hexk) begin
          w_v1     = norm({13'd0, bus.hex_digit});
          w_dcnt   = DW'(1);
          w_newhex = 1'b1;
          w_acc    = 1'b1;
          w_state  = ENTRY2;
        end
      end
      EVAL: begin
        if (r_cnt == CW'(1)) begin
          if (bus.arth_ovw) begin
            w_state = ERROR;
          end else begin
            w_res   = norm(bus.arth_answer);
            w_state = RESULT;
          end
        end
      end
      RESULT: begin
        if (w_op_ok) begin
          w_v2    = r_res;
          w_v1    = '0;
          w_dcnt  = '0;
          w_opc   = bus.op_code;
          w_newop = 1'b1;
          w_acc   = 1'b1;
          w_state = OP_PENDING;
        end else if (w_hexk) begin
          w_v2     = '0;
          w_v1     = norm({13'd0, bus.hex_digit});
          w_dcnt   = DW'(1);
          w_newhex = 1'b1;
          w_acc    = 1'b1;
          w_state  = ENTRY1;
        end
      end
      ERROR:   w_state = ERROR;
      default: w_state = ENTRY1;
    endcase

    if (w_acc) w_cnt = CW'(SETTLE);

    if (bus.clr_valid) begin
      w_state  = ENTRY1;
      w_v1     = '0;
      w_v2     = '0;
      w_res    = '0;
      w_opc    = 2'b00;
      w_dcnt   = '0;
      w_cnt    = '0;
      w_newop  = 1'b1;
      w_newhex = 1'b0;
      w_eq     = 1'b0;
    end

    w_busy = (w_cnt != '0);
    w_err  = (w_state == ERROR);
    case (w_state)
      ENTRY1, ENTRY2: w_disp = w_v1;
      OP_PENDING:     w_disp = w_v2;
      EVAL, RESULT:   w_disp = w_res;
      default:        w_disp = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= ENTRY1;
      r_cnt    <= '0;
      r_dcnt   <= '0;
      r_v1     <= '0;
      r_v2     <= '0;
      r_res    <= '0;
      r_disp   <= '0;
      r_opc    <= 2'b00;
      r_newop  <= 1'b0;
      r_newhex <= 1'b0;
      r_eq     <= 1'b0;
      r_err    <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_cnt    <= w_cnt;
      r_dcnt   <= w_dcnt;
      r_v1     <= w_v1;
      r_v2     <= w_v2;
      r_res    <= w_res;
      r_disp   <= w_disp;
      r_opc    <= w_opc;
      r_newop  <= w_newop;
      r_newhex <= w_newhex;
      r_eq     <= w_eq;
      r_err    <= w_err;
      r_busy   <= w_busy;
    end
  end

  assign bus.V1     = r_v1;
  assign bus.V2     = r_v2;
  assign bus.opcode = r_opc;
  assign bus.newop  = r_newop;
  assign bus.newhex = r_newhex;
  assign bus.eq     = r_eq;
  assign bus.disp   = r_disp;
  assign bus.err    = r_err;
  assign bus.busy   = r_busy;
endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: directed key scenarios plus random key streams against a calculator model.
module tb_calc_sequencer;
  localparam int SETTLE = 3;
  localparam int K_HEX = 0, K_OP = 1, K_EQ = 2, K_NEG = 3, K_CLR = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  calc_sequencer_if bus ();

  calc_sequencer #(.SETTLE(SETTLE), .MAXDIG(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  function automatic longint sm2i(input logic [16:0] v);
    return v[16] ? -longint'(v[15:0]) : longint'(v[15:0]);
  endfunction

  function automatic logic [16:0] i2sm(input longint x);
    longint m;
    m = (x < 0) ? -x : x;
    return {(x < 0) && (m[15:0] != 16'd0), m[15:0]};
  endfunction

  function automatic longint alu(input longint a, input longint b, input logic [1:0] op);
    case (op)
      2'b01:   return a * b;
      2'b10:   return a - b;
      default: return a + b;
    endcase
  endfunction

  // Arithmetic block: answer = V2 op V1, overflow when |answer| exceeds 16 bits.
  longint a_r;
  always_comb begin
    a_r             = alu(sm2i(bus.V2), sm2i(bus.V1), bus.opcode);
    bus.arth_answer = i2sm(a_r);
    bus.arth_ovw    = (a_r > 65535) || (a_r < -65535);
  end

  // Calculator model: phases 0 entry1, 1 op pending, 2 entry2, 4 result, 5 error.
  int          m_ph;
  logic        m_neg;
  longint      m_mag, m_v2, m_res;
  logic [1:0]  m_op;
  int          m_nd;
  logic [2:0]  m_pl;

  task automatic model_clear();
    m_ph = 0; m_neg = 1'b0; m_mag = 0; m_v2 = 0; m_res = 0; m_op = 2'b00; m_nd = 0;
  endtask

  task automatic model_key(input int kind, input logic [3:0] val);
    longint r;
    m_pl = 3'b000;
    if (kind == K_CLR) begin
      model_clear();
      m_pl = 3'b100;
    end else if (m_ph == 0 || m_ph == 2) begin
      if (kind == K_EQ) begin
        m_pl = 3'b001;
        if (m_ph == 0) begin
          m_res = m_neg ? -m_mag : m_mag;
          m_ph  = 4;
        end else begin
          r = alu(m_v2, m_neg ? -m_mag : m_mag, m_op);
          if (r > 65535 || r < -65535) m_ph = 5;
          else begin m_res = r; m_ph = 4; end
        end
      end else if (kind == K_OP && val[1:0] != 2'b11) begin
        if (m_ph == 0) m_v2 = m_neg ? -m_mag : m_mag;
        else m_v2 = sm2i(i2sm(alu(m_v2, m_neg ? -m_mag : m_mag, m_op)));
        m_mag = 0; m_neg = 1'b0; m_nd = 0; m_op = val[1:0]; m_pl = 3'b100; m_ph = 1;
      end else if (kind == K_HEX && m_nd < 4) begin
        m_mag = m_mag * 16 + longint'(val); m_nd++; m_pl = 3'b010;
      end else if (kind == K_NEG) begin
        if (m_mag != 0) m_neg = ~m_neg;
        m_pl = 3'b010;
      end
    end else if (m_ph == 1) begin
      if (kind == K_OP && val[1:0] != 2'b11) begin
        m_op = val[1:0]; m_pl = 3'b100;
      end else if (kind == K_HEX) begin
        m_mag = longint'(val); m_neg = 1'b0; m_nd = 1; m_pl = 3'b010; m_ph = 2;
      end
    end else if (m_ph == 4) begin
      if (kind == K_OP && val[1:0] != 2'b11) begin
        m_v2 = m_res; m_mag = 0; m_neg = 1'b0; m_nd = 0; m_op = val[1:0]; m_pl = 3'b100; m_ph = 1;
      end else if (kind == K_HEX) begin
        m_v2 = 0; m_mag = longint'(val); m_neg = 1'b0; m_nd = 1; m_pl = 3'b010; m_ph = 0;
      end
    end
    if (m_mag == 0) m_neg = 1'b0;
  endtask

  // Drives one key event for a cycle, returns {newop,newhex,eq} seen after it, then lets busy expire.
  task automatic press(input int kind, input logic [3:0] val, output logic [2:0] pl);
    @(negedge clock);
    case (kind)
      K_HEX: begin bus.hex_valid = 1'b1; bus.hex_digit = val; end
      K_OP:  begin bus.op_valid = 1'b1; bus.op_code = val[1:0]; end
      K_EQ:  bus.eq_valid = 1'b1;
      K_NEG: bus.neg_valid = 1'b1;
      default: bus.clr_valid = 1'b1;
    endcase
    @(negedge clock);
    pl = {bus.newop, bus.newhex, bus.eq};
    bus.hex_valid = 1'b0; bus.op_valid = 1'b0; bus.eq_valid = 1'b0;
    bus.neg_valid = 1'b0; bus.clr_valid = 1'b0;
    repeat (SETTLE) @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if ({bus.V1, bus.V2, bus.opcode, bus.newop, bus.newhex, bus.eq, bus.disp, bus.err, bus.busy} !== '0) begin
      errors++;
      $display("FAIL reset_state: V1=%h V2=%h op=%b pulses=%b%b%b disp=%h err=%b busy=%b, want all 0",
               bus.V1, bus.V2, bus.opcode, bus.newop, bus.newhex, bus.eq, bus.disp, bus.err, bus.busy);
    end
    reset = 1'b0;
  endtask

  task automatic test_add();
    logic [2:0] pl;
    press(K_CLR, 0, pl);
    press(K_HEX, 4'h1, pl);
    press(K_HEX, 4'h2, pl);
    press(K_OP, 4'h0, pl);
    checks++;
    if (pl !== 3'b100) begin errors++; $display("FAIL add_newop: pulses=%b want 100", pl); end
    press(K_HEX, 4'h3, pl);
    checks++;
    if (bus.V2 !== 17'h00012 || bus.V1 !== 17'h00003) begin
      errors++; $display("FAIL add_operands: V2=%h V1=%h want 00012 00003", bus.V2, bus.V1);
    end
    press(K_EQ, 0, pl);
    checks++;
    if (pl !== 3'b001) begin errors++; $display("FAIL add_eq_pulse: pulses=%b want 001", pl); end
    checks++;
    if (bus.disp !== 17'h00015 || bus.err !== 1'b0) begin
      errors++; $display("FAIL add_result: disp=%h err=%b want 00015 0", bus.disp, bus.err);
    end
  endtask

  task automatic test_sub();
    logic [2:0] pl;
    press(K_CLR, 0, pl);
    press(K_HEX, 4'h5, pl);
    press(K_OP, 4'h2, pl);
    press(K_HEX, 4'h9, pl);
    checks++;
    if (bus.V2 !== 17'h00005 || bus.V1 !== 17'h00009 || bus.opcode !== 2'b10) begin
      errors++; $display("FAIL sub_operands: V2=%h V1=%h op=%b want 00005 00009 10", bus.V2, bus.V1, bus.opcode);
    end
    press(K_EQ, 0, pl);
    checks++;
    if (bus.disp !== 17'h10004) begin errors++; $display("FAIL sub_result: disp=%h want 10004", bus.disp); end
  endtask

  task automatic test_chain();
    logic [2:0] pl;
    press(K_CLR, 0, pl);
    press(K_HEX, 4'h2, pl);
    press(K_OP, 4'h0, pl);
    press(K_HEX, 4'h3, pl);
    press(K_OP, 4'h1, pl);
    checks++;
    if (bus.V2 !== 17'h00005 || bus.opcode !== 2'b01 || bus.V1 !== 17'h0 || bus.disp !== 17'h00005) begin
      errors++; $display("FAIL chain_fold: V2=%h op=%b V1=%h disp=%h want 00005 01 0 00005",
                         bus.V2, bus.opcode, bus.V1, bus.disp);
    end
    press(K_HEX, 4'h4, pl);
    press(K_EQ, 0, pl);
    checks++;
    if (bus.disp !== 17'h00014) begin errors++; $display("FAIL chain_result: disp=%h want 00014", bus.disp); end
  endtask

  task automatic test_overflow();
    logic [2:0] pl;
    press(K_CLR, 0, pl);
    repeat (4) press(K_HEX, 4'hF, pl);
    press(K_OP, 4'h1, pl);
    press(K_HEX, 4'h2, pl);
    press(K_EQ, 0, pl);
    checks++;
    if (bus.err !== 1'b1 || bus.disp !== 17'h0) begin
      errors++; $display("FAIL ovf_error: err=%b disp=%h want 1 0", bus.err, bus.disp);
    end
    press(K_HEX, 4'h7, pl);
    checks++;
    if (pl !== 3'b000 || bus.err !== 1'b1 || bus.disp !== 17'h0) begin
      errors++; $display("FAIL ovf_digit_ignored: pulses=%b err=%b disp=%h want 000 1 0", pl, bus.err, bus.disp);
    end
    press(K_CLR, 0, pl);
    checks++;
    if (pl !== 3'b100 || {bus.V1, bus.V2, bus.opcode, bus.disp, bus.err, bus.busy} !== '0) begin
      errors++; $display("FAIL ovf_clear: pulses=%b V1=%h V2=%h op=%b disp=%h err=%b want 100 and zeros",
                         pl, bus.V1, bus.V2, bus.opcode, bus.disp, bus.err);
    end
  endtask

  task automatic test_saturation_negate();
    logic [2:0] pl;
    press(K_CLR, 0, pl);
    for (int i = 1; i <= 4; i++) press(K_HEX, 4'(i), pl);
    press(K_HEX, 4'h5, pl);
    checks++;
    if (pl !== 3'b000 || bus.V1 !== 17'h01234) begin
      errors++; $display("FAIL sat_fifth_digit: pulses=%b V1=%h want 000 01234", pl, bus.V1);
    end
    press(K_NEG, 0, pl);
    checks++;
    if (pl !== 3'b010 || bus.V1 !== 17'h11234 || bus.disp !== 17'h11234) begin
      errors++; $display("FAIL neg_toggle: pulses=%b V1=%h disp=%h want 010 11234 11234", pl, bus.V1, bus.disp);
    end
    press(K_CLR, 0, pl);
    press(K_NEG, 0, pl);
    checks++;
    if (bus.V1 !== 17'h0) begin errors++; $display("FAIL neg_zero: V1=%h want 00000", bus.V1); end
  endtask

  task automatic test_busy();
    logic [2:0] pl;
    press(K_CLR, 0, pl);
    @(negedge clock);
    bus.hex_valid = 1'b1; bus.hex_digit = 4'h1;
    @(negedge clock);
    bus.hex_digit = 4'h2;
    checks++;
    if (bus.busy !== 1'b1 || bus.newhex !== 1'b1) begin
      errors++; $display("FAIL busy_after_digit: busy=%b newhex=%b want 1 1", bus.busy, bus.newhex);
    end
    @(negedge clock);
    bus.hex_valid = 1'b0;
    repeat (SETTLE) @(negedge clock);
    checks++;
    if (bus.V1 !== 17'h00001) begin errors++; $display("FAIL busy_drop: V1=%h want 00001", bus.V1); end
    bus.hex_valid = 1'b1; bus.hex_digit = 4'h7; bus.op_valid = 1'b1; bus.op_code = 2'b00;
    @(negedge clock);
    checks++;
    if (bus.newop !== 1'b1 || bus.newhex !== 1'b0) begin
      errors++; $display("FAIL priority_pulses: newop=%b newhex=%b want 1 0", bus.newop, bus.newhex);
    end
    bus.hex_valid = 1'b0; bus.op_valid = 1'b0;
    repeat (SETTLE) @(negedge clock);
    checks++;
    if (bus.V2 !== 17'h00001 || bus.V1 !== 17'h0) begin
      errors++; $display("FAIL priority_regs: V2=%h V1=%h want 00001 00000", bus.V2, bus.V1);
    end
  endtask

  task automatic test_reset_eval();
    logic [2:0] pl;
    press(K_CLR, 0, pl);
    press(K_HEX, 4'h1, pl);
    press(K_OP, 4'h0, pl);
    press(K_HEX, 4'h2, pl);
    @(negedge clock);
    bus.eq_valid = 1'b1;
    @(negedge clock);
    bus.eq_valid = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checks++;
    if ({bus.V1, bus.V2, bus.opcode, bus.newop, bus.newhex, bus.eq, bus.disp, bus.err, bus.busy} !== '0) begin
      errors++; $display("FAIL reset_in_eval: V1=%h V2=%h op=%b pulses=%b%b%b disp=%h err=%b busy=%b want 0",
                         bus.V1, bus.V2, bus.opcode, bus.newop, bus.newhex, bus.eq, bus.disp, bus.err, bus.busy);
    end
    repeat (SETTLE + 1) @(negedge clock);
    checks++;
    if (bus.disp !== 17'h0 || bus.err !== 1'b0) begin
      errors++; $display("FAIL reset_eval_quiet: disp=%h err=%b want 0 0", bus.disp, bus.err);
    end
  endtask

  task automatic test_random();
    logic [2:0]  pl;
    logic [16:0] e_v1, e_v2, e_disp;
    int          r, kind;
    logic [3:0]  val;
    press(K_CLR, 0, pl);
    model_clear();
    for (int n = 0; n < 400; n++) begin
      r   = $urandom_range(0, 99);
      val = 4'($urandom_range(0, 15));
      kind = (r < 45) ? K_HEX : (r < 65) ? K_OP : (r < 80) ? K_EQ : (r < 93) ? K_NEG : K_CLR;
      if (kind == K_OP) val = 4'($urandom_range(0, 3));
      press(kind, val, pl);
      model_key(kind, val);
      e_v1   = {m_neg, m_mag[15:0]};
      e_v2   = i2sm(m_v2);
      e_disp = (m_ph == 0 || m_ph == 2) ? e_v1 : (m_ph == 1) ? e_v2 : (m_ph == 4) ? i2sm(m_res) : 17'h0;
      checks++;
      if (pl !== m_pl || bus.V1 !== e_v1 || bus.V2 !== e_v2 || bus.opcode !== m_op ||
          bus.disp !== e_disp || bus.err !== (m_ph == 5) || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL random_key%0d kind=%0d val=%h: pulses=%b V1=%h V2=%h op=%b disp=%h err=%b busy=%b want %b %h %h %b %h %b 0",
                 n, kind, val, pl, bus.V1, bus.V2, bus.opcode, bus.disp, bus.err, bus.busy,
                 m_pl, e_v1, e_v2, m_op, e_disp, (m_ph == 5));
      end
    end
  endtask

  initial begin
    bus.hex_valid = 1'b0; bus.hex_digit = 4'h0; bus.op_valid = 1'b0; bus.op_code = 2'b00;
    bus.eq_valid = 1'b0; bus.neg_valid = 1'b0; bus.clr_valid = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_chain();
    test_overflow();
    test_saturation_negate();
    test_busy();
    test_reset_eval();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
- Keypad-event sequencer for the hex calculator.
- Turns decoded key events (hex digit, operator, equals, negate, clear) into operand registers V1/V2 and control pulses for the arithmetic module.
- Chains operations through a V2 accumulator, latches final results, and enters an error state on overflow.
- Sits between the keypad decoder and the arithmetic block; drives the display.

Parameters:
- SETTLE, 3, cycles busy after each accepted event; the result/overflow sample point after equals (minimum 2).
- MAXDIG, 4, hex digits accepted per operand.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- hex_valid  in  1  digit key event (1-cycle pulse)
- hex_digit  in  4  digit value
- op_valid  in  1  operator key event
- op_code  in  2  00 add, 01 multiply, 10 subtract (11 ignored)
- eq_valid  in  1  equals key event
- neg_valid  in  1  toggle sign of entry operand
- clr_valid  in  1  clear key event
- arth_answer  in  17  sign-magnitude answer from arithmetic block
- arth_ovw  in  1  overflow flag from arithmetic block (ovw_out)
- V1  out  17  entry operand, sign-magnitude
- V2  out  17  accumulator operand, sign-magnitude
- opcode  out  2  operator to arithmetic block
- newop  out  1  1-cycle pulse, operator accepted
- newhex  out  1  1-cycle pulse, digit or negate accepted
- eq  out  1  1-cycle pulse, equals accepted
- disp  out  17  sign-magnitude value to display
- err  out  1  error indicator
- busy  out  1  events are being dropped

Behaviour:
- All outputs are registered.
- Reset values: V1=V2=0, opcode=00, pulses=0, disp=0, err=0, busy=0, state=ENTRY1, digit count=0, settle counter=0, result=0.
  - Reset wins over everything, including mid-EVAL.
- Event acceptance:
  - Events are accepted only when busy=0.
  - Priority when several are valid in the same cycle: clr > eq > op > hex > neg. Lower-priority events that cycle are dropped.
  - An accepted event, except clr, loads the settle counter with SETTLE. busy = (counter != 0); the counter decrements each cycle.
  - clr is accepted even when busy=1. It has reset effect and additionally pulses newop with opcode 00.
- Pulses:
  - newop, newhex and eq go high for exactly one cycle: the cycle following the accepting edge.
  - V1, V2 and opcode update on that same accepting edge.
- Digit entry (ENTRY1/ENTRY2):
  - V1[15:0] <= {V1[11:0], hex_digit}; digit count +1; newhex pulses.
  - When count = MAXDIG, further digits are dropped: no pulse, no busy.
  - The first digit in ENTRY2 comes from OP_PENDING and clears V1 first.
- neg: toggles V1[16] in ENTRY1/ENTRY2 and pulses newhex. If V1[15:0]=0, the sign stays 0. Ignored in other states.
- Normalisation: any value captured into V1/V2/result with magnitude 0 has its sign forced to 0.
- States and transitions:
  - ENTRY1:
    - op -> V2<=V1, V1<=0, opcode<=op_code, newop; go to OP_PENDING.
    - eq -> result<=V1; go to RESULT.
  - OP_PENDING:
    - digit -> V1<=digit, count=1; go to ENTRY2.
    - op -> opcode replaced, newop pulses, V1/V2 unchanged.
    - eq and neg ignored.
  - ENTRY2:
    - op (chaining) -> V2<=arth_answer, sampled on the accepting edge with the old operator; V1<=0; opcode<=new; newop; go to OP_PENDING.
    - eq -> eq pulse; go to EVAL.
  - EVAL: on the edge where the settle counter reaches 0:
    - arth_ovw=1 -> go to ERROR.
    - otherwise result<=arth_answer; go to RESULT.
  - RESULT:
    - digit -> V2<=0, V1<=digit, count=1; go to ENTRY1.
    - op -> V2<=result, V1<=0, newop; go to OP_PENDING.
    - eq and neg ignored.
  - ERROR: only clr is accepted, returning to ENTRY1.
- Display:
  - disp = V1 in ENTRY1/ENTRY2.
  - disp = V2 in OP_PENDING.
  - disp = result in EVAL/RESULT.
  - disp = 0 in ERROR.
- err = 1 only in ERROR.
- op_code 11 is ignored in every state.

Test Plan:
- Keys 1,2,+,3,= with SETTLE-spaced events -> V2=0x00012, V1=0x00003, then RESULT with disp=0x00015, err=0.
- Keys 5,-,9,= -> V2=0x00005, V1=0x00009; disp=0x10004 (sign 1, magnitude 4).
- Chained keys 2,+,3,*,4,= -> at the multiply press V2<=0x00005 and opcode 01; final disp=0x00014.
- Overflow keys F,F,F,F,*,2,= -> ERROR, err=1, disp=0; a digit is ignored; clr -> ENTRY1 with all registers 0.
- Digit saturation and negate:
  - Keys 1,2,3,4,5 -> V1=0x01234, and the fifth digit produces no newhex.
  - neg -> V1=0x11234.
  - neg with V1=0 -> sign stays 0.
- Busy and reset:
  - A digit 1 cycle after an accepted digit is dropped.
  - hex_valid and op_valid in the same cycle -> only the op is taken.
  - reset asserted during EVAL -> next cycle all outputs are at reset values.
